// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath/memory control bundle
// master: controller side; slave: datapath/memory side.
interface multicycle_controller_if;
  logic [19:0] instr_i;
  logic [3:0]  alu_flags_i;
  logic        mem_ready_i;
  logic        pc_write_o;
  logic        ir_write_o;
  logic        reg_write_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic        adr_src_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  alu_control_o;
  logic [1:0]  result_src_o;
  logic [1:0]  imm_src_o;
  logic [1:0]  reg_src_o;
  logic        fault_o;

  modport master (
    input  instr_i, alu_flags_i, mem_ready_i,
    output pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_read_o,
           adr_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o,
           imm_src_o, reg_src_o, fault_o
  );

  modport slave (
    output instr_i, alu_flags_i, mem_ready_i,
    input  pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_read_o,
           adr_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o,
           imm_src_o, reg_src_o, fault_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM-subset control FSM with NZCV flags and memory timeout
// Optional MULTICYCLE_CTRL_CMP_EN: adds CMP/TST data commands that update flags without writeback.
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  multicycle_controller_if.master bus
);

`ifdef MULTICYCLE_CTRL_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_HALT
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] result_src;
  } ctl_t;

  localparam ctl_t CTL_FETCH = 12'b1000_0110_0010;

  state_t        state, state_next;
  ctl_t          ctl, ctl_next;
  logic [3:0]    flags;
  logic [CW-1:0] wait_cnt;
  logic          fault;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  assign cond  = bus.instr_i[19:16];
  assign op    = bus.instr_i[15:14];
  assign funct = bus.instr_i[13:8];
  assign rd    = bus.instr_i[3:0];
  assign cmd   = funct[4:1];

  logic cmd_cmp, cmd_arith, cmd_legal, cond_ok, n_f, z_f, c_f, v_f;
  logic [1:0] cmd_alu;
  assign cmd_cmp   = CMP_EN && (cmd == 4'b1010 || cmd == 4'b1000);
  assign cmd_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (CMP_EN && cmd == 4'b1010);
  assign cmd_legal = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
                     (cmd == 4'b1100) || cmd_cmp;
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    case (cmd)
      4'b0100: cmd_alu = 2'b00;
      4'b0010, 4'b1010: cmd_alu = 2'b01;
      4'b0000, 4'b1000: cmd_alu = 2'b10;
      4'b1100: cmd_alu = 2'b11;
      default: cmd_alu = 2'b00;
    endcase
  end

  always_comb begin
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Only the three states that talk to memory can wait; everywhere else the counter sits at zero.
  logic mem_state, waiting, timeout_hit;
  assign mem_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign waiting     = mem_state && !bus.mem_ready_i;
  assign timeout_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (bus.mem_ready_i) state_next = S_DECODE;
      S_DECODE: begin
        state_next = S_FETCH;
        if (cond_ok) begin
          case (op)
            2'b00:   if (cmd_legal) state_next = funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_next = S_MEMADR;
            2'b10:   state_next = S_BRANCH;
            default: state_next = S_FETCH;
          endcase
        end
      end
      S_EXECR, S_EXECI: state_next = cmd_cmp ? S_FETCH : S_ALUWB;
      S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready_i) state_next = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready_i) state_next = S_FETCH;
      S_ALUWB, S_MEMWB, S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_HALT;
    endcase
    if (waiting && timeout_hit) state_next = S_HALT;
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    ctl_next = '0;
    case (state_next)
      S_FETCH:  ctl_next = CTL_FETCH;
      S_DECODE: begin
        ctl_next.alu_src_a = 1'b1;
        ctl_next.alu_src_b = 2'b10;
      end
      S_EXECR:  ctl_next.alu_control = cmd_alu;
      S_EXECI: begin
        ctl_next.alu_src_b   = 2'b01;
        ctl_next.alu_control = cmd_alu;
      end
      S_ALUWB, S_MEMWB: begin
        ctl_next.reg_write  = 1'b1;
        ctl_next.pc_write   = (rd == 4'hF);
        ctl_next.result_src = (state_next == S_MEMWB) ? 2'b01 : 2'b00;
      end
      S_MEMADR: begin
        ctl_next.alu_src_b   = 2'b01;
        ctl_next.alu_control = funct[3] ? 2'b00 : 2'b01;
      end
      S_MEMRD: begin
        ctl_next.adr_src  = 1'b1;
        ctl_next.mem_read = 1'b1;
      end
      S_MEMWR: begin
        ctl_next.adr_src   = 1'b1;
        ctl_next.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctl_next.alu_src_b  = 2'b01;
        ctl_next.result_src = 2'b10;
        ctl_next.pc_write   = 1'b1;
      end
      default: ctl_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      ctl      <= CTL_FETCH;
      flags    <= 4'b0000;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      ctl      <= ctl_next;
      fault    <= (state_next == S_HALT);
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if ((state == S_EXECR || state == S_EXECI) && funct[0]) begin
        flags[3:2] <= bus.alu_flags_i[3:2];
        if (cmd_arith) flags[1:0] <= bus.alu_flags_i[1:0];
      end
    end
  end

  // IR/PC load in FETCH follows mem_ready_i within the cycle; reset masks every write and request.
  logic in_fetch;
  assign in_fetch = (state == S_FETCH);

  assign bus.pc_write_o    = !rst_i && (ctl.pc_write || (in_fetch && bus.mem_ready_i));
  assign bus.ir_write_o    = !rst_i && in_fetch && bus.mem_ready_i;
  assign bus.reg_write_o   = !rst_i && ctl.reg_write;
  assign bus.mem_write_o   = !rst_i && ctl.mem_write;
  assign bus.mem_read_o    = !rst_i && ctl.mem_read;
  assign bus.adr_src_o     = ctl.adr_src;
  assign bus.alu_src_a_o   = ctl.alu_src_a;
  assign bus.alu_src_b_o   = ctl.alu_src_b;
  assign bus.alu_control_o = ctl.alu_control;
  assign bus.result_src_o  = ctl.result_src;
  assign bus.imm_src_o     = op;
  assign bus.reg_src_o     = {(op == 2'b01) && !funct[0], (op == 2'b10)};
  assign bus.fault_o       = fault;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed-vector bench for multicycle_controller
module tb_multicycle_controller;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_WAIT_MAX(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // {fault, pc_w, ir_w, reg_w, mem_w, mem_r, adr, src_a, src_b, alu, result}
  logic [13:0] sig;
  assign sig = {bus.fault_o, bus.pc_write_o, bus.ir_write_o, bus.reg_write_o,
                bus.mem_write_o, bus.mem_read_o, bus.adr_src_o, bus.alu_src_a_o,
                bus.alu_src_b_o, bus.alu_control_o, bus.result_src_o};

  localparam logic [13:0] F_RDY   = 14'b01100101100010;
  localparam logic [13:0] F_WAIT  = 14'b00000101100010;
  localparam logic [13:0] RST_F   = 14'b00000001100010;
  localparam logic [13:0] DEC     = 14'b00000001100000;
  localparam logic [13:0] EXI_ADD = 14'b00000000010000;
  localparam logic [13:0] EXI_SUB = 14'b00000000010100;
  localparam logic [13:0] EXR_ORR = 14'b00000000001100;
  localparam logic [13:0] WB      = 14'b00010000000000;
  localparam logic [13:0] WB_PC   = 14'b01010000000000;
  localparam logic [13:0] MADR    = 14'b00000000010000;
  localparam logic [13:0] MRD     = 14'b00000110000000;
  localparam logic [13:0] MWB     = 14'b00010000000001;
  localparam logic [13:0] MWR     = 14'b00001010000000;
  localparam logic [13:0] BR      = 14'b01000000010010;
  localparam logic [13:0] HLT     = 14'b10000000000000;

  // {cond, op, funct, rn, rd}
  localparam logic [19:0] ADDS_R1 = {4'hE, 2'b00, 6'b101001, 4'h0, 4'h1};
  localparam logic [19:0] BEQ     = {4'h0, 2'b10, 6'b100000, 4'h0, 4'h0};
  localparam logic [19:0] BNE     = {4'h1, 2'b10, 6'b100000, 4'h0, 4'h0};
  localparam logic [19:0] ORR_PC  = {4'hE, 2'b00, 6'b011000, 4'h0, 4'hF};
  localparam logic [19:0] NV_ADD  = {4'hF, 2'b00, 6'b101001, 4'h0, 4'h1};
  localparam logic [19:0] UND_OP  = {4'hE, 2'b11, 6'b000000, 4'h0, 4'h1};
  localparam logic [19:0] UND_CMD = {4'hE, 2'b00, 6'b101101, 4'h0, 4'h1};
  localparam logic [19:0] LDR_R2  = {4'hE, 2'b01, 6'b011001, 4'h0, 4'h2};
  localparam logic [19:0] STR_R3  = {4'hE, 2'b01, 6'b011000, 4'h0, 4'h3};
  localparam logic [19:0] CMP_5   = {4'hE, 2'b00, 6'b110101, 4'h0, 4'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [13:0] exp);
    bus.mem_ready_i = rdy;
    #1;
    check(tag, 32'(sig), 32'(exp));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.instr_i     = BEQ;
    bus.alu_flags_i = 4'b0000;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    bus.mem_ready_i = 1'b1;
    #1;
    check("reset_gated", 32'(sig), 32'(RST_F));
    rst_i = 1'b0;

    // flags cleared by reset: BEQ falls through
    cyc("beq0_fetch", 1'b1, F_RDY);
    cyc("beq0_decode", 1'b1, DEC);

    bus.instr_i = ADDS_R1;
    cyc("adds_fetch", 1'b1, F_RDY);
    cyc("adds_decode", 1'b1, DEC);
    bus.alu_flags_i = 4'b0100;
    cyc("adds_execi", 1'b1, EXI_ADD);
    bus.alu_flags_i = 4'b0000;
    cyc("adds_aluwb", 1'b1, WB);

    bus.instr_i = BNE;
    cyc("bne_fetch", 1'b1, F_RDY);
    cyc("bne_decode", 1'b1, DEC);

    bus.instr_i = BEQ;
    cyc("beq_fetch", 1'b1, F_RDY);
    check("beq_srcs", 32'({bus.reg_src_o, bus.imm_src_o}), 32'(4'b0110));
    cyc("beq_decode", 1'b1, DEC);
    cyc("beq_branch", 1'b1, BR);

    bus.instr_i = ORR_PC;
    cyc("orr_fetch", 1'b1, F_RDY);
    cyc("orr_decode", 1'b1, DEC);
    cyc("orr_execr", 1'b1, EXR_ORR);
    cyc("orr_aluwb_pc", 1'b1, WB_PC);

    bus.instr_i = NV_ADD;
    cyc("nv_fetch", 1'b1, F_RDY);
    cyc("nv_decode", 1'b1, DEC);
    bus.instr_i = UND_OP;
    cyc("undop_fetch", 1'b1, F_RDY);
    cyc("undop_decode", 1'b1, DEC);
    bus.instr_i = UND_CMD;
    cyc("undcmd_fetch", 1'b1, F_RDY);
    cyc("undcmd_decode", 1'b1, DEC);

    bus.instr_i = LDR_R2;
    cyc("ldr_fetch", 1'b1, F_RDY);
    cyc("ldr_decode", 1'b1, DEC);
    cyc("ldr_memadr", 1'b1, MADR);
    for (int i = 0; i < 3; i++) cyc("ldr_memrd_wait", 1'b0, MRD);
    cyc("ldr_memrd_done", 1'b1, MRD);
    cyc("ldr_memwb", 1'b1, MWB);

    // CMP loads C=1, Z=0 only when the compare commands exist
    bus.instr_i = CMP_5;
    cyc("cmp_fetch", 1'b1, F_RDY);
    cyc("cmp_decode", 1'b1, DEC);
    bus.alu_flags_i = 4'b0010;
`ifdef MULTICYCLE_CTRL_CMP_EN
    cyc("cmp_execi", 1'b1, EXI_SUB);
`endif
    bus.alu_flags_i = 4'b0000;
    bus.instr_i = BEQ;
    cyc("cmp_beq_fetch", 1'b1, F_RDY);
    cyc("cmp_beq_decode", 1'b1, DEC);
`ifndef MULTICYCLE_CTRL_CMP_EN
    cyc("cmp_beq_branch", 1'b1, BR);
`endif

    bus.instr_i = ADDS_R1;
    cyc("adds2_fetch", 1'b1, F_RDY);
    cyc("adds2_decode", 1'b1, DEC);
    bus.alu_flags_i = 4'b0100;
    cyc("adds2_execi", 1'b1, EXI_ADD);
    bus.alu_flags_i = 4'b0000;
    cyc("adds2_aluwb", 1'b1, WB);

    bus.instr_i = STR_R3;
    cyc("str_fetch", 1'b1, F_RDY);
    check("str_srcs", 32'({bus.reg_src_o, bus.imm_src_o}), 32'(4'b1001));
    cyc("str_decode", 1'b1, DEC);
    cyc("str_memadr", 1'b1, MADR);
    cyc("str_memwr", 1'b0, MWR);
    rst_i = 1'b1;
    #1;
    check("rst_memwr_write", 32'(bus.mem_write_o), 32'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    bus.instr_i = BEQ;
    cyc("post_rst_fetch", 1'b1, F_RDY);
    cyc("post_rst_decode", 1'b1, DEC);

    for (int i = 0; i < 4; i++) cyc("timeout_wait", 1'b0, F_WAIT);
    cyc("halt_a", 1'b1, HLT);
    cyc("halt_b", 1'b1, HLT);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc("halt_cleared", 1'b1, F_RDY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM-subset processor: sequences each instruction through fetch, decode, execute, memory and writeback states over one shared memory port, and stalls on a memory ready handshake. It holds the architectural NZCV flags, evaluates condition codes and bounds memory waits with a fault timeout. It drives the existing datapath mux selects and write enables, which are unchanged in meaning.

## Interface
- MEM_WAIT_MAX, 255, max consecutive cycles a memory state may wait on mem_ready_i before faulting; 0 disables the timeout
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- instr_i  in  20  instruction bits [31:12]: cond[31:28], op[27:26], funct[25:20], rd[15:12]
- alu_flags_i  in  4  NZCV from ALU, current cycle
- mem_ready_i  in  1  memory completes the current read/write this cycle
- pc_write_o  out  1  PC register load
- ir_write_o  out  1  instruction register load
- reg_write_o  out  1  register file write
- mem_write_o  out  1  memory write request
- mem_read_o  out  1  memory read request
- adr_src_o  out  1  0=PC, 1=ALUOut as memory address
- alu_src_a_o  out  1  0=RD1, 1=PC
- alu_src_b_o  out  2  00=RD2, 01=ExtImm, 10=constant 4
- alu_control_o  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- result_src_o  out  2  00=ALUOut, 01=Data, 10=ALU result
- imm_src_o  out  2  = op
- reg_src_o  out  2  [0]=branch (op 10), [1]=store (op 01, funct[0]=0)
- fault_o  out  1  sticky memory-timeout fault

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, HALT.
- FETCH: mem_read_o=1, adr_src 0, src_a 1, src_b 10, ADD, result_src 10; ir_write_o and pc_write_o only in the cycle mem_ready_i=1, then -> DECODE; else stay.
- DECODE: src_a 1, src_b 10, ADD (PC+8). Condition checked against flags register (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 fails). Fail or undefined -> FETCH, no writes. op 00: funct[5] ? EXECI : EXECR; op 01 -> MEMADR; op 10 -> BRANCH; op 11 undefined.
- Data cmd funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; others undefined.
- EXECR/EXECI: src_a 0, src_b 00/01, ALU op per cmd -> ALUWB. If funct[0]=1 flags register loads at cycle end: NZ always, CV only for ADD/SUB.
- ALUWB: result_src 00, reg_write_o=1, pc_write_o=1 if rd=15 -> FETCH.
- MEMADR: src_a 0, src_b 01, ADD if funct[3]=1 else SUB -> funct[0] ? MEMRD : MEMWR.
- MEMRD: adr_src 1, mem_read_o=1; on mem_ready_i -> MEMWB.
- MEMWB: result_src 01, reg_write_o=1, pc_write_o=1 if rd=15 -> FETCH.
- MEMWR: adr_src 1, mem_write_o=1 held until mem_ready_i, then -> FETCH.
- BRANCH: src_a 0, src_b 01, ADD, result_src 10, pc_write_o=1 -> FETCH.
- Wait counter: clears on entering FETCH/MEMRD/MEMWR and on every mem_ready_i; increments each waiting cycle; when it reaches MEM_WAIT_MAX with mem_ready_i=0 -> HALT. HALT: all requests/enables 0, fault_o=1, stays until reset.
- Unlisted selects are don't-care but driven to 0.

## Timing
- Moore outputs except ir/pc write in FETCH, gated by mem_ready_i combinationally.
- Cycles with zero wait: data op 4, load 5, store 4, branch 3, failed cond 2.
- Reset: next edge state=FETCH, flags=0000, counter=0, fault_o=0. While rst_i=1 all write enables and requests forced 0 combinationally; reset mid-instruction aborts it with no writes.
- mem_ready_i in DECODE/EXEC/WB states is ignored.

## Configuration
- MULTICYCLE_CTRL_CMP_EN defined: cmd 1010 CMP (SUB) and 1000 TST (AND) legal; flags update per S-bit rules with CV/NZ as above; ALUWB skipped (EXEC -> FETCH), no register write.
- Undefined: 1010/1000 are undefined instructions (DECODE -> FETCH, no effect).

## Test plan
- ADDS r1 (cond AL, funct 101001), ready always 1 -> states FETCH,DECODE,EXECI,ALUWB; reg_write_o once; flags loaded from alu_flags_i=0100 at EXECI end.
- LDR with mem_ready_i low 3 cycles in MEMRD -> MEMRD held 4 cycles, reg_write_o only in MEMWB; load total 8 cycles.
- flags Z=1, BNE -> DECODE -> FETCH, pc_write_o never asserted in BRANCH; BEQ -> BRANCH with pc_write_o=1.
- MEM_WAIT_MAX=4, mem_ready_i held 0 in FETCH -> HALT after 4 waiting cycles, fault_o=1 until rst_i; all enables 0.
- rst_i asserted in MEMWR with mem_write_o high -> mem_write_o 0 same cycle, state FETCH, flags 0000 next cycle.
- CMP r0,#5 with/without MULTICYCLE_CTRL_CMP_EN -> 3 cycles, flags updated, no reg_write / 2 cycles, flags unchanged.
